// File: rtl/branch_pkg.sv
// Shared types, ALU-op codes and 2-bit saturating counter helpers for the
// branch predictor.
package branch_pkg;

  typedef logic [1:0] bht_ctr_t;

  localparam bht_ctr_t SNT = 2'b00;
  localparam bht_ctr_t WNT = 2'b01;
  localparam bht_ctr_t WT  = 2'b10;
  localparam bht_ctr_t ST  = 2'b11;

  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_JUMP   = 2'b11;

  function automatic bht_ctr_t sat_inc(input bht_ctr_t c);
    return (c == ST) ? ST : bht_ctr_t'(c + 2'b01);
  endfunction

  function automatic bht_ctr_t sat_dec(input bht_ctr_t c);
    return (c == SNT) ? SNT : bht_ctr_t'(c - 2'b01);
  endfunction

endpackage

// File: rtl/bht_table.sv
// Direct-mapped BTB/BHT storage: one combinational lookup port and one
// read-modify-write update port driven by the resolve stage.
module bht_table
  import branch_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IDX_W = $clog2(DEPTH),
  parameter int TAG_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [31:0]      rd_tgt,
  output bht_ctr_t         rd_ctr,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic [TAG_W-1:0] upd_tag,
  input  logic             upd_taken,
  input  logic [31:0]      upd_target
);

  logic             valid_q [DEPTH];
  logic [TAG_W-1:0] tag_q   [DEPTH];
  logic [31:0]      tgt_q   [DEPTH];
  bht_ctr_t         ctr_q   [DEPTH];

  logic upd_hit;

  // Lookup sees the state before any same-cycle update lands.
  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_tgt   = tgt_q[rd_idx];
  assign rd_ctr   = ctr_q[rd_idx];

  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        ctr_q[i]   <= WNT;
      end
    end else if (upd_en) begin
      if (upd_hit) begin
        ctr_q[upd_idx] <= upd_taken ? sat_inc(ctr_q[upd_idx]) : sat_dec(ctr_q[upd_idx]);
        if (upd_taken) tgt_q[upd_idx] <= upd_target;
      end else if (upd_taken) begin
        // Only taken misses allocate; not-taken misses leave the entry alone.
        valid_q[upd_idx] <= 1'b1;
        tag_q[upd_idx]   <= upd_tag;
        tgt_q[upd_idx]   <= upd_target;
        ctr_q[upd_idx]   <= WT;
      end
    end
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch resolution and dynamic prediction: IF-side BTB/BHT lookup, EX-side
// outcome resolution, mispredict detection, registered redirect and statistics.
module branch_predict_unit
  import branch_pkg::*;
#(
  parameter int PC_W      = 9,
  parameter int BHT_DEPTH = 16,
  parameter int IDX_W     = $clog2(BHT_DEPTH),
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PC_W-1:0]  if_pc,
  output logic             pred_taken,
  output logic [31:0]      pred_target,
  input  logic             ex_valid,
  input  logic [PC_W-1:0]  ex_pc,
  input  logic [31:0]      ex_imm,
  input  logic [31:0]      ex_reg1,
  input  logic             ex_branch,
  input  logic [1:0]       ex_aluop,
  input  logic             ex_cond,
  input  logic             ex_pred_taken,
  input  logic [31:0]      ex_pred_target,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispredict_cnt
);

  localparam int TAG_W = PC_W - IDX_W - 2;

  logic [31:0]      if_pc_ext;
  logic [31:0]      ex_pc_ext;
  logic             rd_valid;
  logic [TAG_W-1:0] rd_tag;
  logic [31:0]      rd_tgt;
  bht_ctr_t         rd_ctr;
  logic             hit;

  logic        jump;
  logic        taken;
  logic [31:0] target;
  logic [31:0] next_pc;
  logic        live;
  logic        mispred;

  assign if_pc_ext = {{(32-PC_W){1'b0}}, if_pc};
  assign ex_pc_ext = {{(32-PC_W){1'b0}}, ex_pc};

  bht_table #(
    .DEPTH (BHT_DEPTH),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_table (
    .clk        (clk),
    .reset      (reset),
    .rd_idx     (if_pc[IDX_W+1:2]),
    .rd_valid   (rd_valid),
    .rd_tag     (rd_tag),
    .rd_tgt     (rd_tgt),
    .rd_ctr     (rd_ctr),
    .upd_en     (live && ex_branch),
    .upd_idx    (ex_pc[IDX_W+1:2]),
    .upd_tag    (ex_pc[PC_W-1:IDX_W+2]),
    .upd_taken  (taken),
    .upd_target (target)
  );

  assign hit         = rd_valid && (rd_tag == if_pc[PC_W-1:IDX_W+2]);
  assign pred_taken  = hit && rd_ctr[1];
  assign pred_target = pred_taken ? rd_tgt : if_pc_ext + 32'd4;

  // An instruction sitting behind a redirect is wrong-path and must not count.
  always_comb begin
    jump    = (ex_aluop == ALUOP_JUMP);
    taken   = ex_branch && (jump || ex_cond);
    target  = jump ? ((ex_reg1 + ex_imm) & ~32'h1) : (ex_pc_ext + ex_imm);
    next_pc = taken ? target : (ex_pc_ext + 32'd4);
    live    = ex_valid && !redirect_valid;
    mispred = live && ((ex_pred_taken != taken) ||
                       (taken && (ex_pred_target != target)));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      redirect_valid <= mispred;
      if (mispred) redirect_pc <= next_pc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
    end else begin
      if (live && ex_branch && (branch_cnt != '1))
        branch_cnt <= branch_cnt + CNT_W'(1);
      if (mispred && (mispredict_cnt != '1))
        mispredict_cnt <= mispredict_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench for branch_predict_unit: directed scenarios plus random
// traffic checked against a behavioural predictor model.
module tb_branch_predict_unit;

  localparam int PC_W  = 9;
  localparam int DEPTH = 16;
  localparam int CNT_W = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [PC_W-1:0]  if_pc = '0;
  logic             pred_taken;
  logic [31:0]      pred_target;
  logic             ex_valid = 1'b0;
  logic [PC_W-1:0]  ex_pc = '0;
  logic [31:0]      ex_imm = '0;
  logic [31:0]      ex_reg1 = '0;
  logic             ex_branch = 1'b0;
  logic [1:0]       ex_aluop = '0;
  logic             ex_cond = 1'b0;
  logic             ex_pred_taken = 1'b0;
  logic [31:0]      ex_pred_target = '0;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispredict_cnt;

  branch_predict_unit #(
    .PC_W      (PC_W),
    .BHT_DEPTH (DEPTH),
    .CNT_W     (CNT_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .if_pc          (if_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .ex_valid       (ex_valid),
    .ex_pc          (ex_pc),
    .ex_imm         (ex_imm),
    .ex_reg1        (ex_reg1),
    .ex_branch      (ex_branch),
    .ex_aluop       (ex_aluop),
    .ex_cond        (ex_cond),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .branch_cnt     (branch_cnt),
    .mispredict_cnt (mispredict_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    int          bcnt;
    int          mcnt;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference predictor state: plain integers, counter strength 0..3.
  int          m_valid [DEPTH];
  int          m_tag   [DEPTH];
  logic [31:0] m_tgt   [DEPTH];
  int          m_ctr   [DEPTH];
  logic        m_rv;
  logic [31:0] m_rpc;
  int          m_bcnt;
  int          m_mcnt;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      m_valid[i] = 0;
      m_tag[i]   = 0;
      m_tgt[i]   = 32'h0;
      m_ctr[i]   = 1;
    end
    m_rv = 1'b0;
    m_rpc = 32'h0;
    m_bcnt = 0;
    m_mcnt = 0;
  endtask

  task automatic model_lookup(input int pc, output logic tk, output logic [31:0] tg);
    int idx;
    idx = (pc / 4) % DEPTH;
    tk = (m_valid[idx] != 0) && (m_tag[idx] == pc / (4 * DEPTH)) && (m_ctr[idx] >= 2);
    tg = tk ? m_tgt[idx] : 32'(pc + 4);
  endtask

  // Drive one EX cycle at the falling edge, check the lookup, then push the
  // response expected after the next rising edge and advance the model.
  task automatic apply_stimulus(input logic vld, input int pc, input logic [31:0] imm,
                                input logic [31:0] reg1, input logic br, input logic [1:0] op,
                                input logic cond, input logic ptk, input logic [31:0] ptg,
                                input int ifpc);
    logic        jump, tk, mis, live, ltk;
    logic [31:0] pc32, tgt, nxt, ltg;
    int          idx;
    exp_t        e;
    @(negedge clk);
    ex_valid = vld; ex_pc = PC_W'(pc); ex_imm = imm; ex_reg1 = reg1;
    ex_branch = br; ex_aluop = op; ex_cond = cond;
    ex_pred_taken = ptk; ex_pred_target = ptg; if_pc = PC_W'(ifpc);
    #1;
    model_lookup(ifpc, ltk, ltg);
    check_output("lookup_taken", {31'b0, pred_taken}, {31'b0, ltk});
    check_output("lookup_target", pred_target, ltg);

    pc32 = 32'(pc);
    jump = (op == 2'b11);
    tk   = br && (jump || cond);
    tgt  = jump ? ((reg1 + imm) & ~32'h1) : (pc32 + imm);
    nxt  = tk ? tgt : pc32 + 32'd4;
    live = vld && !m_rv;
    mis  = live && ((ptk != tk) || (tk && ptg != tgt));
    if (live && br) begin
      if (m_bcnt < CNT_MAX) m_bcnt++;
      idx = (pc / 4) % DEPTH;
      if (m_valid[idx] != 0 && m_tag[idx] == pc / (4 * DEPTH)) begin
        if (tk) begin
          if (m_ctr[idx] < 3) m_ctr[idx]++;
          m_tgt[idx] = tgt;
        end else if (m_ctr[idx] > 0) m_ctr[idx]--;
      end else if (tk) begin
        m_valid[idx] = 1;
        m_tag[idx]   = pc / (4 * DEPTH);
        m_tgt[idx]   = tgt;
        m_ctr[idx]   = 2;
      end
    end
    if (mis && m_mcnt < CNT_MAX) m_mcnt++;
    m_rv = mis;
    if (mis) m_rpc = nxt;
    e.rv = m_rv; e.rpc = m_rpc; e.bcnt = m_bcnt; e.mcnt = m_mcnt;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int ifpc);
    apply_stimulus(1'b0, 0, 32'h0, 32'h0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, ifpc);
  endtask

  // Monitor: one registered response per rising edge once stimulus is queued.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!reset && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_output("redirect_valid", {31'b0, redirect_valid}, {31'b0, e.rv});
      check_output("redirect_pc", redirect_pc, e.rpc);
      check_output("branch_cnt", 32'(branch_cnt), 32'(e.bcnt));
      check_output("mispredict_cnt", 32'(mispredict_cnt), 32'(e.mcnt));
    end
  end

  initial begin
    logic        ptk;
    logic [31:0] ptg;
    int          pc, op;
    model_clear();
    if_pc = 9'h010;
    #2;
    check_output("reset_pred_taken", {31'b0, pred_taken}, 32'h0);
    check_output("reset_pred_target", pred_target, 32'h14);
    check_output("reset_redirect_valid", {31'b0, redirect_valid}, 32'h0);
    check_output("reset_redirect_pc", redirect_pc, 32'h0);
    check_output("reset_counts", 32'(branch_cnt) | 32'(mispredict_cnt), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // BEQ taken with no prediction: redirect then allocation
    apply_stimulus(1'b1, 'h20, 32'h40, 32'h0, 1'b1, 2'b01, 1'b1, 1'b0, 32'h0, 'h20);
    idle('h20);
    check_output("beq_redirect_valid", {31'b0, redirect_valid}, 32'h1);
    check_output("beq_redirect_pc", redirect_pc, 32'h60);
    check_output("alloc_pred_taken", {31'b0, pred_taken}, 32'h1);
    check_output("alloc_pred_target", pred_target, 32'h60);

    // Counter walk: 10 -> 01 -> 00 -> 00, then two taken to predict again
    for (int k = 0; k < 5; k++) begin
      model_lookup('h20, ptk, ptg);
      apply_stimulus(1'b1, 'h20, 32'h40, 32'h0, 1'b1, 2'b01, (k >= 3), ptk, ptg, 'h20);
      idle('h20);
      if (k == 1) check_output("two_nt_pred_taken", {31'b0, pred_taken}, 32'h0);
      if (k == 3) check_output("one_t_from_snt", {31'b0, pred_taken}, 32'h0);
    end
    check_output("two_t_pred_taken", {31'b0, pred_taken}, 32'h1);

    // JALR target LSB clearing, correct and wrong predicted target
    apply_stimulus(1'b1, 'h40, 32'h4, 32'h101, 1'b1, 2'b11, 1'b0, 1'b1, 32'h104, 'h40);
    idle('h40);
    check_output("jalr_ok_no_redirect", {31'b0, redirect_valid}, 32'h0);
    apply_stimulus(1'b1, 'h40, 32'h4, 32'h101, 1'b1, 2'b11, 1'b0, 1'b1, 32'h105, 'h40);
    idle('h40);
    check_output("jalr_bad_redirect_pc", redirect_pc, 32'h104);

    // Alias mispredict followed by a wrong-path branch that must be ignored
    apply_stimulus(1'b1, 'h80, 32'h0, 32'h0, 1'b0, 2'b00, 1'b0, 1'b1, 32'h100, 'hC0);
    apply_stimulus(1'b1, 'hC0, 32'h8, 32'h0, 1'b1, 2'b01, 1'b1, 1'b0, 32'h0, 'hC0);
    idle('hC0);
    check_output("wrong_path_no_redirect", {31'b0, redirect_valid}, 32'h0);
    check_output("wrong_path_no_alloc", {31'b0, pred_taken}, 32'h0);
    check_output("alias_redirect_pc", redirect_pc, 32'h84);

    // Random traffic over a small PC window so entries alias and hit
    for (int n = 0; n < 500; n++) begin
      pc = int'($urandom_range(0, 127)) * 4;
      op = int'($urandom_range(0, 3));
      model_lookup(pc, ptk, ptg);
      if ($urandom_range(0, 3) == 0) begin
        ptk = 1'($urandom);
        ptg = $urandom_range(0, 511);
      end
      apply_stimulus(($urandom_range(0, 9) != 0), pc, 32'(int'($urandom_range(0, 255)) - 128),
                     $urandom, (op[0] == 1'b1) || ($urandom_range(0, 7) == 0), 2'(op),
                     1'($urandom), ptk, ptg, int'($urandom_range(0, 127)) * 4);
    end
    idle(0);

    // Asynchronous reset while a redirect is being presented
    apply_stimulus(1'b1, 'h1A0, 32'h10, 32'h0, 1'b1, 2'b01, 1'b1, 1'b0, 32'h0, 'h1A0);
    @(negedge clk);
    check_output("pre_reset_redirect", {31'b0, redirect_valid}, 32'h1);
    reset = 1'b1;
    ex_valid = 1'b0;
    #1;
    check_output("async_reset_redirect", {31'b0, redirect_valid}, 32'h0);
    check_output("async_reset_table", {31'b0, pred_taken}, 32'h0);
    check_output("async_reset_counts", 32'(branch_cnt) | 32'(mispredict_cnt), 32'h0);
    exp_q.delete();
    model_clear();
    @(negedge clk);
    reset = 1'b0;

    // Mispredict counter saturation
    for (int n = 0; n < CNT_MAX + 20; n++) begin
      apply_stimulus(1'b1, 'h100, 32'h0, 32'h0, 1'b0, 2'b00, 1'b0, 1'b1, 32'h0, 'h100);
      idle('h100);
    end
    idle(0);
    check_output("mispredict_cnt_sat", 32'(mispredict_cnt), 32'(CNT_MAX));

    @(negedge clk);
    check_output("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
